// File: rtl/fm_modulator_ramped.sv
`default_nettype none
// ============================================================================
// Module      : fm_modulator_ramped
// Description : Phase-accumulator FM modulator with a piecewise-linear sine,
//               a 2-stage output pipeline and a click-free carrier amplitude
//               ramp. Optional LFSR phase dither when FM_DITHER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fm_modulator_ramped #(
  parameter int A        = 8,
  parameter int N        = 18,
  parameter int D        = 5,
  parameter int S        = 3,
  parameter int AMPW     = 4,
  parameter int RAMP_LOG = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [A-1:0] audio,
  input  logic         audio_valid,
  input  logic [N-1:0] acc_inc,
  input  logic         tune_we,
  input  logic [S-1:0] dev_shift,
  input  logic         tx_en,
  output logic [D-1:0] rf,
  output logic [1:0]   state
);

  localparam int R  = D - 1;
  localparam int PW = (RAMP_LOG > 0) ? RAMP_LOG : 1;
  localparam logic [AMPW:0] c_amp_full     = {1'b1, {AMPW{1'b0}}};
  localparam logic [D-1:0]  c_mid          = {1'b1, {(D-1){1'b0}}};
  localparam logic [R-1:0]  c_quarter      = R'(1 << (R - 2));
  localparam logic [PW-1:0] c_presc_term   = PW'((1 << RAMP_LOG) - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t             r_state;
  logic signed [A-1:0] r_audio;
  logic [N-1:0]       r_inc;
  logic [N-1:0]       r_phase;
  logic [AMPW:0]      r_amp;
  logic [PW-1:0]      r_presc;
  logic [R-1:0]       r_mag;
  logic               r_neg;
  logic [D-1:0]       r_rf;

  logic [N-1:0]       w_mod_inc;
  logic [N-1:0]       w_step;
  logic [1:0]         w_q;
  logic [R-1:0]       w_p;
  logic [R-1:0]       w_f;
  logic [1:0]         w_seg;
  logic [R-1:0]       w_mag;
  logic [R+AMPW:0]    w_prod;
  logic [R-1:0]       w_ms;
  logic [D-1:0]       w_rf;

  assign w_mod_inc = N'(r_audio) << dev_shift;

`ifdef FM_DITHER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_step = r_inc + w_mod_inc + N'(r_lfsr[3:0]);
`else
  assign w_step = r_inc + w_mod_inc;
`endif

  // Quadrant fold: odd quadrants mirror the phase, the upper half negates.
  assign w_q   = r_phase[N-1:N-2];
  assign w_p   = r_phase[N-3 -: R];
  assign w_f   = w_q[0] ? ~w_p : w_p;
  assign w_seg = w_f[R-1:R-2];

  always_comb begin
    w_mag = '1;
    case (w_seg)
      2'd0:    w_mag = {w_f[R-2:0], 1'b0};
      2'd3:    w_mag = '1;
      default: w_mag = c_quarter + w_f;
    endcase
  end

  assign w_prod = (R+AMPW+1)'(r_mag) * (R+AMPW+1)'(r_amp);
  assign w_ms   = R'(w_prod >> AMPW);
  assign w_rf   = r_neg ? (c_mid - D'(w_ms)) : (c_mid + D'(w_ms));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_audio <= '0;
      r_inc   <= '0;
      r_phase <= '0;
      r_mag   <= '0;
      r_neg   <= 1'b0;
      r_rf    <= c_mid;
    end else begin
      if (audio_valid) r_audio <= audio;
      if (tune_we)     r_inc   <= acc_inc;
      r_phase <= (r_state == IDLE) ? '0 : (r_phase + w_step);
      r_mag   <= w_mag;
      r_neg   <= w_q[1];
      r_rf    <= w_rf;
    end
  end

  // Direction changes keep the current amplitude so keying never clicks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_amp   <= '0;
      r_presc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_presc <= '0;
          if (tx_en) r_state <= RAMP_UP;
        end
        RAMP_UP: begin
          if (!tx_en) begin
            r_state <= RAMP_DOWN;
            r_presc <= '0;
          end else if (r_amp == c_amp_full) begin
            r_state <= ON;
            r_presc <= '0;
          end else if (r_presc == c_presc_term) begin
            r_presc <= '0;
            r_amp   <= r_amp + 1'b1;
            if (r_amp == c_amp_full - 1'b1) r_state <= ON;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        ON: begin
          r_amp   <= c_amp_full;
          r_presc <= '0;
          if (!tx_en) r_state <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (tx_en) begin
            r_state <= RAMP_UP;
            r_presc <= '0;
          end else if (r_amp == '0) begin
            r_state <= IDLE;
            r_presc <= '0;
          end else if (r_presc == c_presc_term) begin
            r_presc <= '0;
            r_amp   <= r_amp - 1'b1;
            if (r_amp == (AMPW+1)'(1)) r_state <= IDLE;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rf    = r_rf;
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fm_modulator_ramped.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_modulator_ramped
// Description : Directed self-checking bench for fm_modulator_ramped.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fm_modulator_ramped;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  audio = '0;
  logic        audio_valid = 1'b0;
  logic [17:0] acc_inc = '0;
  logic        tune_we = 1'b0;
  logic [2:0]  dev_shift = '0;
  logic        tx_en = 1'b0;
  logic [4:0]  rf;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  fm_modulator_ramped dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .audio       (audio),
    .audio_valid (audio_valid),
    .acc_inc     (acc_inc),
    .tune_we     (tune_we),
    .dev_shift   (dev_shift),
    .tx_en       (tx_en),
    .rf          (rf),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    total++; if (rf !== 5'd16) begin bad++; $display("FAIL reset_rf: got %0d want 16", rf); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      total++; if (rf !== 5'd16) begin bad++; $display("FAIL idle_rf[%0d]: got %0d want 16", i, rf); end
      total++; if (state !== 2'd0) begin bad++; $display("FAIL idle_state[%0d]: got %0d want 0", i, state); end
    end
  endtask

  task automatic test_ramp_up();
    logic [4:0] v [8];
    logic [4:0] pat [4];
    int j;
    pat[0] = 5'd31; pat[1] = 5'd16; pat[2] = 5'd1; pat[3] = 5'd16;
    acc_inc = 18'd65536; tune_we = 1'b1; audio = 8'd0; audio_valid = 1'b1; tx_en = 1'b1;
    tick();
    tune_we = 1'b0; audio_valid = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      total++; if (state !== 2'd1) begin bad++; $display("FAIL ramp_up_state[%0d]: got %0d want 1", i, state); end
      tick();
    end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL on_state: got %0d want 2", state); end
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin v[i] = rf; tick(); end
    j = -1;
    for (int i = 3; i >= 0; i--) if (v[i] == 5'd31) j = i;
    total++;
    if (j < 0) begin
      bad++; $display("FAIL on_pattern: no 31 in %0d %0d %0d %0d", v[0], v[1], v[2], v[3]);
    end else begin
      for (int k = 1; k < 4; k++) begin
        total++; if (v[j+k] !== pat[k]) begin bad++; $display("FAIL on_pattern[%0d]: got %0d want %0d", k, v[j+k], pat[k]); end
      end
    end
  endtask

  task automatic test_ramp_down();
    int peak [16];
    int d;
    int viol;
    int n;
    tx_en = 1'b0;
    tick();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL ramp_down_state: got %0d want 3", state); end
    for (int w = 0; w < 16; w++) begin
      peak[w] = 0;
      for (int s = 0; s < 4; s++) begin
        d = int'(rf) - 16;
        if (d < 0) d = -d;
        if (d > peak[w]) peak[w] = d;
        tick();
      end
    end
    viol = 0;
    for (int w = 1; w < 16; w++) if (peak[w] > peak[w-1]) viol++;
    total++; if (viol != 0) begin bad++; $display("FAIL ramp_down_monotonic: got %0d increases want 0", viol); end
    total++; if (peak[0] != 15) begin bad++; $display("FAIL ramp_down_first_peak: got %0d want 15", peak[0]); end
    total++; if (peak[15] >= peak[0]) begin bad++; $display("FAIL ramp_down_decay: got last %0d first %0d", peak[15], peak[0]); end
    n = 0;
    while (state !== 2'd0 && n < 20) begin tick(); n++; end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL ramp_down_idle: got %0d want 0 (timeout)", state); end
    repeat (3) tick();
    total++; if (rf !== 5'd16) begin bad++; $display("FAIL ramp_down_rf: got %0d want 16", rf); end
  endtask

  task automatic test_deviation();
    logic [4:0] v [8];
    logic [4:0] pat [4];
    int j;
    int n;
    pat[0] = 5'd31; pat[1] = 5'd16; pat[2] = 5'd1; pat[3] = 5'd16;
    acc_inc = 18'd81920; tune_we = 1'b1; audio = 8'h80; audio_valid = 1'b1; dev_shift = 3'd7; tx_en = 1'b1;
    tick();
    tune_we = 1'b0; audio_valid = 1'b0;
    n = 0;
    while (state !== 2'd2 && n < 100) begin tick(); n++; end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL dev_on: got %0d want 2 (timeout)", state); end
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin v[i] = rf; tick(); end
    j = -1;
    for (int i = 3; i >= 0; i--) if (v[i] == 5'd31) j = i;
    total++;
    if (j < 0) begin
      bad++; $display("FAIL dev_pattern: no 31 in %0d %0d %0d %0d", v[0], v[1], v[2], v[3]);
    end else begin
      for (int k = 1; k < 4; k++) begin
        total++; if (v[j+k] !== pat[k]) begin bad++; $display("FAIL dev_pattern[%0d]: got %0d want %0d", k, v[j+k], pat[k]); end
      end
    end
    tx_en = 1'b0;
    n = 0;
    while (state !== 2'd0 && n < 100) begin tick(); n++; end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL dev_back_idle: got %0d want 0 (timeout)", state); end
  endtask

  task automatic test_pulse_and_async_reset();
    int d;
    int pk;
    acc_inc = 18'd65536; tune_we = 1'b1; audio = 8'd0; audio_valid = 1'b1; dev_shift = 3'd0; tx_en = 1'b1;
    tick();
    tune_we = 1'b0; audio_valid = 1'b0;
    repeat (32) tick();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL pulse_pre: got %0d want 1", state); end
    tx_en = 1'b0;
    tick();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL pulse_down: got %0d want 3", state); end
    tx_en = 1'b1;
    tick();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL pulse_up: got %0d want 1", state); end
    pk = 0;
    for (int s = 0; s < 3; s++) begin
      tick();
      d = int'(rf) - 16;
      if (d < 0) d = -d;
      if (d > pk) pk = d;
    end
    total++; if (pk < 6 || pk > 7) begin bad++; $display("FAIL pulse_amp: got peak %0d want 6..7", pk); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rf !== 5'd16) begin bad++; $display("FAIL async_rst_rf: got %0d want 16", rf); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL async_rst_state: got %0d want 0", state); end
    tx_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_tune_freeze();
    int n;
    logic [4:0] prev;
    logic found;
    acc_inc = 18'd65536; tune_we = 1'b1; tx_en = 1'b1;
    tick();
    tune_we = 1'b0;
    n = 0;
    while (state !== 2'd2 && n < 100) begin tick(); n++; end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL freeze_on: got %0d want 2 (timeout)", state); end
    repeat (3) tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev = rf;
      tick();
      if (prev == 5'd31 && rf == 5'd16) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL freeze_sync: got no 31->16 step want one"); end
    acc_inc = 18'd0; tune_we = 1'b1;
    tick();
    tune_we = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (rf !== 5'd31) begin bad++; $display("FAIL freeze_rf[%0d]: got %0d want 31", i, rf); end
      tick();
    end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL freeze_state: got %0d want 2", state); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_deviation();
    test_pulse_and_async_reset();
    test_tune_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
